// File: rtl/brew_controller.sv
// Brew sequencer: accepts a scanned code, checks water and cup, then runs timed heater/grinder/pump/valve phases.
// Latency: 1 + HEAT + GRIND + BREW + DISPENSE clocks from code acceptance to the one-cycle done pulse.
// Backpressure: none; the scanner is held off via scan_enable outside IDLE, and aborts act at the next edge.
module brew_controller #(
  parameter int unsigned HEAT_CYCLES     = 8,
  parameter int unsigned GRIND_CYCLES    = 4,
  parameter int unsigned BREW_CYCLES     = 6,
  parameter int unsigned DISPENSE_CYCLES = 3,
  parameter int unsigned CUP_TIMEOUT     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_valid,
  input  logic       cup_present,
  input  logic       water_ok,
  input  logic       cancel,
  input  logic       err_clr,
  output logic       scan_enable,
  output logic       heater_on,
  output logic       grinder_on,
  output logic       pump_on,
  output logic       valve_open,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CHECK    = 4'd1,
    S_WAIT_CUP = 4'd2,
    S_HEAT     = 4'd3,
    S_GRIND    = 4'd4,
    S_BREW     = 4'd5,
    S_DISPENSE = 4'd6,
    S_DONE     = 4'd7,
    S_ERROR    = 4'd8
  } state_e;

  // A phase ends when the counter reaches its length minus one.
  localparam logic [7:0] HEAT_LAST  = 8'(HEAT_CYCLES - 1);
  localparam logic [7:0] GRIND_LAST = 8'(GRIND_CYCLES - 1);
  localparam logic [7:0] BREW_LAST  = 8'(BREW_CYCLES - 1);
  localparam logic [7:0] DISP_LAST  = 8'(DISPENSE_CYCLES - 1);
  localparam logic [7:0] CUP_LAST   = 8'(CUP_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] err_q, err_d;
  logic [7:0] phase_last;
  state_e     phase_next;
  logic       timed;
  logic       abort;
  logic [1:0] abort_code;

  // Abort decode for the brew phases: cancel beats low water, which beats a missing cup.
  always_comb begin
    abort      = 1'b1;
    abort_code = 2'b11;
    if (cancel)           abort_code = 2'b11;
    else if (!water_ok)   abort_code = 2'b01;
    else if (!cup_present) abort_code = 2'b10;
    else begin
      abort      = 1'b0;
      abort_code = 2'b00;
    end
  end

  // Per-state phase length and successor for the timed states.
  always_comb begin
    phase_last = 8'd0;
    phase_next = S_IDLE;
    timed      = 1'b1;
    case (state_q)
      S_WAIT_CUP: phase_last = CUP_LAST;
      S_HEAT:     begin phase_last = HEAT_LAST;  phase_next = S_GRIND;    end
      S_GRIND:    begin phase_last = GRIND_LAST; phase_next = S_BREW;     end
      S_BREW:     begin phase_last = BREW_LAST;  phase_next = S_DISPENSE; end
      S_DISPENSE: begin phase_last = DISP_LAST;  phase_next = S_DONE;     end
      default:    timed = 1'b0;
    endcase
  end

  // Next-state, fault-code and phase-counter logic.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:  if (code_valid) state_d = S_CHECK;
      S_CHECK: begin
        if (!water_ok) begin
          state_d = S_ERROR;
          err_d   = 2'b01;
        end else if (!cup_present) begin
          state_d = S_WAIT_CUP;
        end else begin
          state_d = S_HEAT;
        end
      end
      S_WAIT_CUP: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (cup_present) begin
          state_d = S_HEAT;
        end else if (cnt_q == phase_last) begin
          state_d = S_ERROR;
          err_d   = 2'b10;
        end
      end
      S_HEAT, S_GRIND, S_BREW, S_DISPENSE: begin
        if (abort) begin
          state_d = S_ERROR;
          err_d   = abort_code;
        end else if (cnt_q == phase_last) begin
          state_d = phase_next;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: begin
        if (err_clr) begin
          state_d = S_IDLE;
          err_d   = 2'b00;
        end
      end
      default: begin
        state_d = S_IDLE;
        err_d   = 2'b00;
      end
    endcase
    // Counter restarts on every state entry and only runs in timed states.
    if (state_d != state_q || !timed) cnt_d = 8'd0;
    else                               cnt_d = cnt_q + 8'd1;
  end

  // State, phase counter and fault code registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Moore outputs decoded straight from the state register, so reset clears them at once.
  always_comb begin
    scan_enable = (state_q == S_IDLE);
    heater_on   = (state_q == S_HEAT);
    grinder_on  = (state_q == S_GRIND);
    pump_on     = (state_q == S_BREW);
    valve_open  = (state_q == S_DISPENSE);
    busy        = (state_q != S_IDLE) && (state_q != S_ERROR);
    done        = (state_q == S_DONE);
    error       = (state_q == S_ERROR);
    err_code    = err_q;
    state       = state_q;
  end

endmodule

// File: tb/tb_brew_controller.sv
// Bench for brew_controller: scenario timelines built from phase lengths, compared slot by slot.
// Latency: expected outputs are queued per clock slot and checked mid-slot by an independent monitor.
// Backpressure: none; stimulus runs open-loop, don't-care inputs are randomised.
module tb_brew_controller;

  localparam int HEAT   = 8;
  localparam int GRIND  = 4;
  localparam int BREW   = 6;
  localparam int DISP   = 3;
  localparam int CUPTO  = 10;
  localparam int ACTIVE = HEAT + GRIND + BREW + DISP;

  localparam int L_IDLE = 0, L_CHECK = 1, L_WAIT = 2, L_HEAT = 3, L_GRIND = 4;
  localparam int L_BREW = 5, L_DISP = 6, L_DONE = 7, L_ERR = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       code_valid, cup_present, water_ok, cancel, err_clr;
  logic       scan_enable, heater_on, grinder_on, pump_on, valve_open;
  logic       busy, done, error;
  logic [1:0] err_code;
  logic [3:0] state;

  brew_controller #(
    .HEAT_CYCLES(HEAT), .GRIND_CYCLES(GRIND), .BREW_CYCLES(BREW),
    .DISPENSE_CYCLES(DISP), .CUP_TIMEOUT(CUPTO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .cup_present(cup_present),
    .water_ok(water_ok), .cancel(cancel), .err_clr(err_clr),
    .scan_enable(scan_enable), .heater_on(heater_on), .grinder_on(grinder_on),
    .pump_on(pump_on), .valve_open(valve_open), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic cv, cup, wat, can, clr;
  } stim_t;

  typedef struct packed {
    logic [3:0] lab;
    logic [1:0] ec;
  } lab_t;

  stim_t       stim_q[$];
  lab_t        lab_q[$];
  logic [13:0] exp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          slot_no = 0;
  logic [13:0] got;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected output vector for a slot spent in a given spec state with a given fault code.
  function automatic logic [13:0] outs(input logic [3:0] lab, input logic [1:0] ec);
    return {lab == 4'd0, lab == 4'd3, lab == 4'd4, lab == 4'd5, lab == 4'd6,
            (lab != 4'd0 && lab != 4'd8), lab == 4'd7, lab == 4'd8, ec, lab};
  endfunction

  function automatic logic [13:0] cur();
    return {scan_enable, heater_on, grinder_on, pump_on, valve_open,
            busy, done, error, err_code, state};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s at slot %0d: got %b, expected %b", name, slot_no, act, want);
  endtask

  task automatic slot(input int lab, input logic [1:0] ec, input logic cv, input logic cup,
                      input logic wat, input logic can, input logic clr);
    stim_t s;
    lab_t  l;
    s.cv = cv; s.cup = cup; s.wat = wat; s.can = can; s.clr = clr;
    l.lab = 4'(lab); l.ec = ec;
    stim_q.push_back(s);
    lab_q.push_back(l);
  endtask

  task automatic idle_tail();
    for (int k = 0; k < 2; k++) slot(L_IDLE, 2'b00, 1'b0, rb(), rb(), rb(), rb());
  endtask

  // ERROR for a few slots, then err_clr (possibly with a fresh code, which must be ignored).
  task automatic err_tail(input logic [1:0] ec);
    int e;
    e = $urandom_range(1, 4);
    for (int k = 0; k < e; k++) slot(L_ERR, ec, rb(), rb(), rb(), rb(), k == e - 1);
    idle_tail();
  endtask

  // kind: 0 straight brew, 1 no water, 2 late cup, 3 cup timeout, 4 cancel while waiting,
  // 5 abort in a brew phase. p = wait length or abort offset (-1 random), f = {cancel, water low, cup gone}.
  task automatic gen(input int kind, input int p, input logic [2:0] f);
    int         w, a, lab;
    logic [2:0] fl;
    logic       cup, can;
    slot(L_IDLE, 2'b00, 1'b1, rb(), rb(), rb(), rb());
    slot(L_CHECK, 2'b00, rb(), !(kind >= 2 && kind <= 4), kind != 1, rb(), rb());
    if (kind == 1) begin err_tail(2'b01); return; end
    if (kind >= 2 && kind <= 4) begin
      w = (kind == 3) ? CUPTO : ((p > 0) ? p : $urandom_range(1, CUPTO));
      for (int j = 1; j <= w; j++) begin
        can = (kind == 4 && j == w);
        cup = (kind == 2 && j == w) || (kind == 4 && j == w && rb());
        slot(L_WAIT, 2'b00, rb(), cup, rb(), can, rb());
      end
      if (kind == 3) begin err_tail(2'b10); return; end
      if (kind == 4) begin idle_tail(); return; end
    end
    a  = (kind == 5) ? ((p >= 0) ? p : $urandom_range(0, ACTIVE - 1)) : -1;
    fl = (f != 3'b000) ? f : 3'($urandom_range(1, 7));
    for (int i = 0; i < ACTIVE; i++) begin
      lab = (i < HEAT) ? L_HEAT : (i < HEAT + GRIND) ? L_GRIND :
            (i < HEAT + GRIND + BREW) ? L_BREW : L_DISP;
      if (i == a) begin
        slot(lab, 2'b00, rb(), !fl[0], !fl[1], fl[2], rb());
        err_tail(fl[2] ? 2'b11 : fl[1] ? 2'b01 : 2'b10);
        return;
      end
      slot(lab, 2'b00, rb(), 1'b1, 1'b1, 1'b0, rb());
    end
    slot(L_DONE, 2'b00, rb(), rb(), rb(), rb(), rb());
    idle_tail();
  endtask

  // Driver: applies one queued stimulus per slot and hands the expectation to the monitor.
  task automatic run();
    stim_t s;
    lab_t  l;
    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      s = stim_q.pop_front();
      l = lab_q.pop_front();
      code_valid = s.cv; cup_present = s.cup; water_ok = s.wat; cancel = s.can; err_clr = s.clr;
      exp_q.push_back(outs(l.lab, l.ec));
    end
    @(posedge clk);
    #1;
    code_valid = 1'b0; cup_present = 1'b1; water_ok = 1'b1; cancel = 1'b0; err_clr = 1'b0;
  endtask

  // Monitor: mid-slot comparison of every output against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      got = cur();
      check("slot_outputs", got, exp_q.pop_front());
      slot_no++;
    end
  end

  initial begin
    code_valid = 1'b0; cup_present = 1'b1; water_ok = 1'b1; cancel = 1'b0; err_clr = 1'b0;
    rst_n = 1'b0;
    #12;
    check("reset_outputs", cur(), outs(4'd0, 2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("idle_after_release", cur(), outs(4'd0, 2'b00));

    gen(0, -1, 3'b000);
    gen(1, -1, 3'b000);
    gen(2, 4, 3'b000);
    gen(3, -1, 3'b000);
    gen(5, HEAT + GRIND + 2, 3'b110);
    gen(4, -1, 3'b000);
    gen(5, ACTIVE - 1, 3'b001);
    gen(2, CUPTO, 3'b000);
    run();

    repeat (40) gen($urandom_range(0, 5), -1, 3'b000);
    run();

    // Asynchronous reset in the middle of HEAT.
    @(posedge clk);
    #1 code_valid = 1'b1;
    @(posedge clk);
    #1 code_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 check("heat_before_reset", cur(), outs(4'd3, 2'b00));
    rst_n = 1'b0;
    #1 check("reset_mid_heat", cur(), outs(4'd0, 2'b00));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1 check("idle_wait_code", cur(), outs(4'd0, 2'b00));
    end
    gen(0, -1, 3'b000);
    run();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/brew_controller.md
# brew_controller

Sequences one coffee brew after an access code is accepted. Sits directly downstream of the code scanner in the coffee-machine FSM: drives the scanner's `enable`, consumes its `code_valid`, then runs heater, grinder, pump and dispense valve through fixed-length phases. It also checks cup presence and water level, and latches a fault code.

## Interface
- `HEAT_CYCLES`, 8, heater phase length in clocks (1..255)
- `GRIND_CYCLES`, 4, grinder phase length (1..255)
- `BREW_CYCLES`, 6, pump phase length (1..255)
- `DISPENSE_CYCLES`, 3, valve phase length (1..255)
- `CUP_TIMEOUT`, 10, max clocks to wait for a cup (1..255)

Ports:
- `clk` in 1: single clock; all state changes on its rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `code_valid` in 1: from scanner; level, meaningful only while `scan_enable`=1
- `cup_present` in 1: cup sensor, 1 = cup in place
- `water_ok` in 1: water-level sensor, 1 = enough water
- `cancel` in 1: user abort, level-sampled each clock
- `err_clr` in 1: clears the ERROR state
- `scan_enable` out 1: scanner enable; 1 only in IDLE
- `heater_on`, `grinder_on`, `pump_on`, `valve_open` out 1 each: actuator drives
- `busy` out 1: 1 in every state except IDLE and ERROR
- `done` out 1: one-cycle pulse on brew completion
- `error` out 1: 1 in ERROR
- `err_code` out 2: 00 none, 01 no water, 10 cup timeout/removed, 11 cancelled mid-brew
- `state` out 4: current state encoding (debug)

## Operation
- States and encoding: IDLE=0, CHECK=1, WAIT_CUP=2, HEAT=3, GRIND=4, BREW=5, DISPENSE=6, DONE=7, ERROR=8.
- Moore outputs are decoded from the state register:
  - `heater_on`=1 in HEAT.
  - `grinder_on`=1 in GRIND.
  - `pump_on`=1 in BREW.
  - `valve_open`=1 in DISPENSE.
  - `done`=1 in DONE.
- `err_code` is a register. It is loaded on entry to ERROR, holds while in ERROR, and is cleared to 00 on leaving ERROR.
- An 8-bit phase counter is zeroed on every state entry and increments each clock in timed states. A phase exits when counter == LEN-1, so each phase lasts exactly LEN clocks.
- Transitions:
  - IDLE: `code_valid`=1 -> CHECK. `cancel` is ignored in IDLE.
  - CHECK (1 clock):
    - `water_ok`=0 -> ERROR/01
    - else `cup_present`=0 -> WAIT_CUP
    - else -> HEAT
  - WAIT_CUP:
    - `cancel` -> IDLE (no error)
    - else `cup_present` -> HEAT
    - else after CUP_TIMEOUT clocks -> ERROR/10
  - HEAT -> GRIND -> BREW -> DISPENSE -> DONE, each on phase completion.
  - DONE (1 clock) -> IDLE.
  - ERROR: `err_clr` -> IDLE. Otherwise holds.
- Priority in HEAT..DISPENSE, highest first:
  1. `cancel` -> ERROR/11
  2. `water_ok`=0 -> ERROR/01
  3. `cup_present`=0 -> ERROR/10
  4. phase completion
- The abort checks apply on every clock of the phase, including the final one.
- Scanner handshake: `scan_enable` drops on entry to CHECK. The scanner then clears `code_valid` on the following edge. Because IDLE is not re-entered for at least 2 clocks, the same code is never re-accepted.

## Timing
- Reset (`rst_n`=0, asynchronous) forces:
  - state IDLE, counter 0, `err_code` 00
  - `scan_enable`=1
  - all other outputs 0
- Reset mid-brew de-energises all actuators immediately, without waiting for a clock.
- Release of `rst_n` is synchronised by the design convention. The first active edge acts from IDLE.
- Edge numbering: `code_valid` sampled high at edge n means CHECK is occupied in cycle n+1.
- With a cup present and default parameters:
  - HEAT occupies cycles n+2..n+9
  - GRIND n+10..n+13
  - BREW n+14..n+19
  - DISPENSE n+20..n+22
  - DONE n+23
  - IDLE n+24
- Total latency from acceptance to `done` is 1+HEAT+GRIND+BREW+DISPENSE clocks.
- Abort inputs and `err_clr` take effect at the next edge. Actuators are 0 in the cycle after the abort condition is sampled.
- If `err_clr` and a new `code_valid` arrive together, the controller goes to IDLE only. The code is evaluated from IDLE on later edges.

## Test plan
- Reset, then `code_valid`=1 at edge 0 with cup and water present -> CHECK in cycle 1; `heater_on` in cycles 2-9; `grinder_on` 10-13; `pump_on` 14-19; `valve_open` 20-22; `done`=1 only in cycle 23; `scan_enable`=1 again in cycle 24.
- `water_ok`=0 at CHECK -> ERROR in the next cycle with `err_code`=01; no actuator ever set. `err_clr` pulse -> IDLE, `err_code`=00.
- `cup_present`=0 at CHECK, cup inserted 4 clocks later -> HEAT begins on the following cycle. Repeat with no cup -> ERROR/10 after exactly 10 WAIT_CUP cycles.
- `cancel` asserted in the 3rd BREW cycle while `water_ok` also drops -> ERROR with `err_code`=11 (cancel wins); `pump_on` is 0 next cycle.
- `cancel` in WAIT_CUP -> IDLE with `error`=0. Cup removed in the last DISPENSE cycle -> ERROR/10, no `done`.
- `rst_n` pulled low mid-HEAT between edges -> `heater_on`=0 and `scan_enable`=1 immediately. After release, the controller remains in IDLE until `code_valid` is seen.
